// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: routes one valid/ready stream to N channels,
// with one registered slot per channel and a saturating drop counter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready producer handshake
//   in_data, in_sel   payload and destination channel index
//   out_valid[k]      channel k holds a beat
//   out_ready[k]      consumer k takes its beat this cycle
//   out_data          channel k payload at [k*WIDTH +: WIDTH]
//   drop_cnt          accepted beats with in_sel >= N (saturating)
module demux_1xn_stream #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int CNTW = 8,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [CNTW-1:0]    drop_cnt
);

  localparam logic [SELW:0] NCH = (SELW+1)'(N);

  logic [N-1:0]            valid_q;
  logic [N-1:0][WIDTH-1:0] data_q;
  logic [CNTW-1:0]         drop_q;
  logic                    in_range;
  logic                    acc;

  assign in_range = {1'b0, in_sel} < NCH;

  // An out-of-range select is always taken (and dropped).
  // The OR short-circuits before the index can go out of bounds.
  assign in_ready = !in_range
                 || !valid_q[in_sel]
                 || out_ready[in_sel];

  // Gated by in_valid so don't-care sel/data never reach state.
  assign acc = in_valid && in_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        // Load wins over drain: same-cycle drain plus refill.
        if (acc && in_range && in_sel == SELW'(k)) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= in_data;
        end else if (out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (acc && !in_range && drop_q != '1) begin
        drop_q <= drop_q + CNTW'(1);
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb_demux_1xn_stream: directed and random checks of two instances
// (N=4/CNTW=8 and N=3/CNTW=2) against a slot-per-channel model.
module tb_demux_1xn_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;

  logic        rdy4, rdy3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [7:0]  dc4;
  logic [1:0]  dc3;

  demux_1xn_stream #(.N(4), .WIDTH(8), .CNTW(8)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .drop_cnt(dc4)
  );

  demux_1xn_stream #(.N(3), .WIDTH(8), .CNTW(2)) u3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .in_sel(in_sel),
    .out_valid(ov3), .out_ready(out_ready[2:0]),
    .out_data(od3), .drop_cnt(dc3)
  );

  int tests = 0;
  int fails = 0;

  // Model: m=0 is the N=4 instance, m=1 the N=3 instance.
  bit         mv [2][4];
  logic [7:0] md [2][4];
  int         mc [2];
  int         nch [2]  = '{4, 3};
  int         cmax [2] = '{255, 3};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(int m);
    if (int'(in_sel) >= nch[m]) return 1'b1;
    return !mv[m][in_sel] || out_ready[in_sel];
  endfunction

  task automatic m_clear();
    for (int m = 0; m < 2; m++) begin
      mc[m] = 0;
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = 8'h00;
      end
    end
  endtask

  // One clock: drive, check in_ready, edge, update model, check outputs.
  task automatic cyc(bit r, bit v, logic [1:0] s,
                     logic [7:0] d, logic [3:0] ordy);
    bit          acc [2];
    logic [3:0]  ev [2];
    logic [31:0] ed [2];
    rst = r; in_valid = v; in_sel = s;
    in_data = d; out_ready = ordy;
    #1;
    chk("in_ready4", 32'(rdy4), 32'(m_ready(0)));
    chk("in_ready3", 32'(rdy3), 32'(m_ready(1)));
    for (int m = 0; m < 2; m++) acc[m] = v && m_ready(m) && !r;
    @(posedge clk);
    if (r) m_clear();
    else begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < nch[m]; k++)
          if (mv[m][k] && ordy[k]) mv[m][k] = 1'b0;
        if (acc[m]) begin
          if (int'(s) < nch[m]) begin
            mv[m][s] = 1'b1;
            md[m][s] = d;
          end else if (mc[m] < cmax[m]) begin
            mc[m] = mc[m] + 1;
          end
        end
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      ev[m] = '0;
      ed[m] = '0;
      for (int k = 0; k < nch[m]; k++) begin
        ev[m][k] = mv[m][k];
        ed[m][k*8 +: 8] = md[m][k];
      end
    end
    chk("out_valid4", 32'(ov4), 32'(ev[0]));
    chk("out_valid3", 32'(ov3), 32'(ev[1]));
    chk("out_data4", od4, ed[0]);
    chk("out_data3", 32'(od3), ed[1]);
    chk("drop_cnt4", 32'(dc4), 32'(mc[0]));
    chk("drop_cnt3", 32'(dc3), 32'(mc[1]));
  endtask

  initial begin
    logic [1:0] exp_drop [5];
    exp_drop = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset with in_valid high: first edge brings DUT to a known state.
    m_clear();
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1;
    in_data = 8'hEE; out_ready = 4'h0;
    @(posedge clk);
    #1;
    cyc(1, 1, 2'd2, 8'hDD, 4'h0);
    chk("rst_valid4", 32'(ov4), 32'h0);
    chk("rst_drop4", 32'(dc4), 32'h0);

    // Idle: ready for every select.
    rst = 1'b0; in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk("idle_ready4", 32'(rdy4), 32'h1);
      chk("idle_ready3", 32'(rdy3), 32'h1);
    end

    // Routing, one-hot sequence.
    for (int s = 0; s < 4; s++) begin
      cyc(0, 1, 2'(s), 8'hA0 + 8'(s), 4'hF);
      chk("route_onehot", 32'(ov4), 32'(4'b0001 << s));
      chk("route_data", 32'(od4[s*8 +: 8]), 32'(8'hA0 + s));
    end
    cyc(0, 0, 2'd0, 8'h00, 4'hF);

    // Back-pressure isolation on ch1.
    cyc(0, 1, 2'd1, 8'h11, 4'b1101);
    cyc(0, 1, 2'd1, 8'h22, 4'b1101);
    chk("bp_hold", 32'(od4[15:8]), 32'h11);
    cyc(0, 1, 2'd2, 8'h33, 4'b1101);
    chk("bp_other", 32'(od4[23:16]), 32'h33);
    cyc(0, 1, 2'd1, 8'h22, 4'b1111);
    chk("bp_refill", 32'(od4[15:8]), 32'h22);

    // Full throughput on ch0.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 2'd0, 8'(i), 4'b0001);
      chk("tput_valid", 32'(ov4[0]), 32'h1);
      chk("tput_data", 32'(od4[7:0]), 32'(i));
    end

    // Drop path on the N=3 instance.
    cyc(1, 0, 2'd0, 8'h00, 4'hF);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 2'd3, 8'($urandom), 4'hF);
      chk("drop_seq", 32'(dc3), 32'(exp_drop[i]));
      chk("drop_novalid", 32'(ov3), 32'h0);
    end

    // Reset mid-operation.
    cyc(1, 0, 2'd0, 8'h00, 4'h0);
    cyc(0, 1, 2'd0, 8'h5C, 4'h0);
    cyc(0, 1, 2'd2, 8'hC5, 4'h0);
    cyc(0, 1, 2'd3, 8'h01, 4'h0);
    cyc(0, 1, 2'd3, 8'h02, 4'h0);
    chk("mid_pre_drop", 32'(dc3), 32'h2);
    cyc(1, 1, 2'd1, 8'h77, 4'h0);
    chk("mid_valid", 32'(ov3), 32'h0);
    chk("mid_data", 32'(od3), 32'h0);
    chk("mid_drop", 32'(dc3), 32'h0);
    cyc(0, 1, 2'd2, 8'h5A, 4'h0);
    chk("mid_5a", 32'(od3[23:16]), 32'h5A);
    chk("mid_5a_valid", 32'(ov3), 32'b100);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0),
          1'($urandom),
          2'($urandom),
          8'($urandom),
          4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
